// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
//   STATUS_OFF / TOHOST_OFF : MMIO register offsets from MMIO_BASE
//   STATUS_*_BIT            : STATUS register field positions
//   cap_entry_t             : capture FIFO payload {index, data}
package dmem_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned LANES         = WORD_W / 8;

   localparam logic [31:0] STATUS_OFF    = 32'h0000_0000;
   localparam logic [31:0] TOHOST_OFF    = 32'h0000_0004;

   localparam int unsigned STATUS_DONE_BIT = 31;
   localparam int unsigned STATUS_OVF_BIT  = 30;
   localparam int unsigned STATUS_CNT_W    = 16;

   localparam int unsigned CAP_WORDS_DEF = 16;
   localparam int unsigned CAP_IDX_W     = $clog2(CAP_WORDS_DEF);

   typedef struct packed {
      logic [CAP_IDX_W-1:0] index;
      logic [WORD_W-1:0]    data;
   } cap_entry_t;

   // Assemble the STATUS read value from its fields.
   function automatic logic [WORD_W-1:0] status_word(input logic done,
                                                     input logic ovf,
                                                     input logic [STATUS_CNT_W-1:0] count);
      logic [WORD_W-1:0] w;
      w                  = '0;
      w[STATUS_DONE_BIT] = done;
      w[STATUS_OVF_BIT]  = ovf;
      w[STATUS_CNT_W-1:0] = count;
      return w;
   endfunction

endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   push/push_data : enqueue; ignored when full unless a pop happens the same cycle
//   pop            : dequeue head; ignored when empty
//   head_c         : current head entry (valid while !empty_c)
//   full_c/empty_c : occupancy flags, count : registered occupancy
module sync_fifo
   import dmem_pkg::*;
#(
   parameter int unsigned WIDTH = 36,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_c,
   output logic                       full_c,
   output logic                       empty_c,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_fire;
   logic             pop_fire;

   assign full_c    = (count == CW'(DEPTH));
   assign empty_c   = (count == '0);
   assign pop_fire  = pop & ~empty_c;
   // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
   assign push_fire = push & (~full_c | pop_fire);
   assign head_c    = mem[rd_ptr];

   // Storage: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (push_fire) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_fire) wr_ptr <= wr_ptr + AW'(1);
         if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_fire, pop_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for cpu_top's d_mem_* port: word RAM with byte lanes,
// a capture window streaming full-word stores to a host FIFO, and MMIO
// STATUS/TOHOST registers for self-checking runs.
//   d_mem_addr/wdata/wen : CPU access (wen==0 is a read/idle)
//   d_mem_rdata          : zero-latency read data
//   res_valid/ready/index/data : capture stream (valid/ready)
//   done/done_code       : first TOHOST write
//   overflow             : sticky capture-drop flag
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned MEM_WORDS  = 1024,
   parameter logic [31:0] CAP_BASE   = 32'h0000_0400,
   parameter int unsigned CAP_WORDS  = CAP_WORDS_DEF,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [31:0] MMIO_BASE  = 32'h0001_0000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [31:0]                  d_mem_addr,
   input  logic [31:0]                  d_mem_wdata,
   input  logic [3:0]                   d_mem_wen,
   output logic [31:0]                  d_mem_rdata,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [$clog2(CAP_WORDS)-1:0] res_index,
   output logic [31:0]                  res_data,
   output logic                         done,
   output logic [31:0]                  done_code,
   output logic                         overflow
);

   localparam int unsigned RAM_AW    = $clog2(MEM_WORDS);
   localparam int unsigned IDX_W     = $clog2(CAP_WORDS);
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
   localparam logic [31:0] CAP_END   = CAP_BASE + 32'(4 * CAP_WORDS);
   localparam logic [31:0] STATUS_A  = MMIO_BASE + STATUS_OFF;
   localparam logic [31:0] TOHOST_A  = MMIO_BASE + TOHOST_OFF;

   logic [31:0]       ram [MEM_WORDS];
   logic [31:0]       word_addr;
   logic [31:0]       cap_off;
   logic [RAM_AW-1:0] ram_idx;
   logic [IDX_W-1:0]  cap_idx;
   logic              ram_hit;
   logic              cap_hit;
   logic              status_hit;
   logic              tohost_hit;
   logic              full_wr;
   logic              cap_push;
   logic              res_pop;
   logic              ovf_event;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   cap_entry_t        push_entry;
   cap_entry_t        head_entry;
   logic              unused_ok;

   // Address decode; byte offset within the word is ignored everywhere.
   assign word_addr  = {d_mem_addr[31:2], 2'b00};
   assign cap_off    = word_addr - CAP_BASE;
   assign ram_idx    = word_addr[RAM_AW+1:2];
   assign cap_idx    = cap_off[IDX_W+1:2];
   assign ram_hit    = (word_addr < RAM_BYTES);
   assign cap_hit    = (word_addr >= CAP_BASE) && (word_addr < CAP_END);
   assign status_hit = (word_addr == STATUS_A);
   assign tohost_hit = (word_addr == TOHOST_A);
   assign full_wr    = (d_mem_wen == 4'b1111);
   assign unused_ok  = ^{d_mem_addr[1:0], cap_off[31:IDX_W+2], cap_off[1:0]};

   // RAM lane write; contents are never reset and writes are blocked in reset.
   always_ff @(posedge clk) begin
      if (rst_n && ram_hit) begin
         for (int i = 0; i < LANES; i++) begin
            if (d_mem_wen[i]) ram[ram_idx][8*i +: 8] <= d_mem_wdata[8*i +: 8];
         end
      end
   end

   // Capture push: only full-word stores inside the window.
   assign cap_push   = rst_n & full_wr & cap_hit;
   assign res_pop    = res_valid & res_ready;
   assign ovf_event  = cap_push & fifo_full & ~res_pop;
   assign push_entry = '{index: CAP_IDX_W'(cap_idx), data: d_mem_wdata};

   sync_fifo #(
      .WIDTH ($bits(cap_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cap_push),
      .push_data (push_entry),
      .pop       (res_pop),
      .head_c    (head_entry),
      .full_c    (fifo_full),
      .empty_c   (fifo_empty),
      .count     (fifo_count)
   );

   assign res_valid = ~fifo_empty;
   assign res_index = IDX_W'(head_entry.index);
   assign res_data  = head_entry.data;

   // MMIO registers; a same-cycle overflow event beats a software clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         done      <= 1'b0;
         done_code <= '0;
      end else begin
         if (ovf_event) begin
            overflow <= 1'b1;
         end else if (status_hit && full_wr && d_mem_wdata[STATUS_OVF_BIT]) begin
            overflow <= 1'b0;
         end
         if (tohost_hit && full_wr && !done) begin
            done      <= 1'b1;
            done_code <= d_mem_wdata;
         end
      end
   end

   // Zero-latency read mux; unmapped addresses read as zero.
   always_comb begin
      d_mem_rdata = '0;
      if (ram_hit) begin
         d_mem_rdata = ram[ram_idx];
      end else if (status_hit) begin
         d_mem_rdata = status_word(done, overflow, STATUS_CNT_W'(fifo_count));
      end else if (tohost_hit) begin
         d_mem_rdata = done_code;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] d_mem_addr;
   logic [31:0] d_mem_wdata;
   logic [3:0]  d_mem_wen;
   logic [31:0] d_mem_rdata;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_index;
   logic [31:0] res_data;
   logic        done;
   logic [31:0] done_code;
   logic        overflow;

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .d_mem_addr  (d_mem_addr),
      .d_mem_wdata (d_mem_wdata),
      .d_mem_wen   (d_mem_wen),
      .d_mem_rdata (d_mem_rdata),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_index   (res_index),
      .res_data    (res_data),
      .done        (done),
      .done_code   (done_code),
      .overflow    (overflow)
   );

   localparam logic [31:0] STATUS_A = 32'h0001_0000;
   localparam logic [31:0] TOHOST_A = 32'h0001_0004;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   // Reference model: memory image, capture queue, MMIO state.
   logic [31:0] ram_m [1024];
   bit          known [1024];
   logic [35:0] q [$];
   bit          m_ovf;
   bit          m_done;
   logic [31:0] m_code;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      logic [31:0] aw;
      aw = {a[31:2], 2'b00};
      if (aw < 32'h1000)  return ram_m[aw[11:2]];
      if (aw == STATUS_A) return {m_done, m_ovf, 14'b0, 16'(q.size())};
      if (aw == TOHOST_A) return m_code;
      return 32'h0;
   endfunction

   // Effect of one clock edge on the model, from the pre-edge state.
   task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                             input bit rdy, input bit rn);
      logic [31:0] aw;
      bit          in_win;
      bit          ovf_ev;
      aw     = {a[31:2], 2'b00};
      in_win = (aw >= 32'h400) && (aw < 32'h440);
      ovf_ev = 1'b0;
      if (!rn) begin
         q.delete();
         m_ovf  = 1'b0;
         m_done = 1'b0;
         m_code = 32'h0;
         return;
      end
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (w == 4'hF && in_win) begin
         if (q.size() < 16) q.push_back({4'((aw - 32'h400) / 4), d});
         else ovf_ev = 1'b1;
      end
      if (aw < 32'h1000) begin
         for (int i = 0; i < 4; i++)
            if (w[i]) ram_m[aw[11:2]][8*i +: 8] = d[8*i +: 8];
         if (w == 4'hF) known[aw[11:2]] = 1'b1;
      end
      if (ovf_ev) m_ovf = 1'b1;
      else if (aw == STATUS_A && w == 4'hF && d[30]) m_ovf = 1'b0;
      if (aw == TOHOST_A && w == 4'hF && !m_done) begin
         m_done = 1'b1;
         m_code = d;
      end
   endtask

   task automatic rd_check(input logic [31:0] a);
      logic [31:0] aw;
      aw = {a[31:2], 2'b00};
      d_mem_addr = a;
      #1;
      if (aw < 32'h1000 && !known[aw[11:2]]) return;
      check("rdata", d_mem_rdata, model_rd(a));
   endtask

   task automatic check_state();
      check("res_valid", 32'(res_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("res_index", 32'(res_index), 32'(q[0][35:32]));
         check("res_data", res_data, q[0][31:0]);
      end
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("done", 32'(done), 32'(m_done));
      check("done_code", done_code, m_code);
      rd_check(STATUS_A);
   endtask

   task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                        input bit rdy, input bit rn);
      @(negedge clk);
      d_mem_addr  = a;
      d_mem_wdata = d;
      d_mem_wen   = w;
      res_ready   = rdy;
      rst_n       = rn;
      model_step(a, d, w, rdy, rn);
      @(posedge clk);
      #1;
      d_mem_wen = 4'h0;
      res_ready = 1'b0;
      rst_n     = 1'b1;
      check_state();
   endtask

   function automatic logic [31:0] pick_addr();
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r <= 3)      a = 32'h400 + 4 * $urandom_range(0, 15);
      else if (r <= 5) a = 4 * $urandom_range(0, 63);
      else if (r == 6) a = STATUS_A;
      else if (r == 7) a = TOHOST_A;
      else if (r == 8) a = 32'h0002_0000 + 32'($urandom_range(0, 16'hFFFF));
      else             a = 4 * $urandom_range(1000, 1023);
      return a | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [3:0]  w;
      logic [31:0] d;
      rst_n       = 1'b0;
      d_mem_addr  = '0;
      d_mem_wdata = '0;
      d_mem_wen   = '0;
      res_ready   = 1'b0;
      m_ovf       = 1'b0;
      m_done      = 1'b0;
      m_code      = '0;

      // Reset state
      cycle(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      cycle(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      rd_check(STATUS_A);
      check("reset_status", d_mem_rdata, 32'h0);
      rd_check(32'h0003_0000);
      check("unmapped_zero", d_mem_rdata, 32'h0);

      // Byte lanes
      cycle(32'h10, 32'h1122_3344, 4'hF, 1'b0, 1'b1);
      cycle(32'h10, 32'h0000_AA00, 4'b0010, 1'b0, 1'b1);
      rd_check(32'h12);
      check("lane_merge", d_mem_rdata, 32'h1122_AA44);

      // Capture with host stalled, then drain
      cycle(32'h400, 32'h7, 4'hF, 1'b0, 1'b1);
      cycle(32'h404, 32'hFFFF_FFF9, 4'hF, 1'b0, 1'b1);
      check("cap_head", {28'(res_index), res_data[3:0]}, {28'h0, 4'h7});
      check("cap_count", d_mem_rdata, 32'h2);
      cycle(32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
      check("cap_second", res_data, 32'hFFFF_FFF9);
      cycle(32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
      check("cap_drained", 32'(res_valid), 32'h0);

      // Overflow: 17 stores into a 16-entry FIFO
      for (int i = 0; i < 17; i++)
         cycle(32'h400 + 32'(4 * (i % 16)), 32'h100 + 32'(i), 4'hF, 1'b0, 1'b1);
      check("ovf_count", d_mem_rdata, 32'h4000_0010);
      for (int i = 0; i < 16; i++) rd_check(32'h400 + 32'(4 * i));
      cycle(STATUS_A, 32'h4000_0000, 4'hF, 1'b0, 1'b1);
      check("ovf_cleared", 32'(overflow), 32'h0);

      // Full FIFO, push and pop together
      cycle(32'h43C, 32'h8000_0000, 4'hF, 1'b1, 1'b1);
      check("full_pushpop", d_mem_rdata, 32'h0000_0010);
      for (int i = 0; i < 15; i++) cycle(32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
      check("last_entry", {28'(res_index), 4'h0} ^ res_data, {28'hF, 4'h0} ^ 32'h8000_0000);
      cycle(32'h0, 32'h0, 4'h0, 1'b1, 1'b1);

      // TOHOST is write-once
      cycle(TOHOST_A, 32'h1, 4'hF, 1'b0, 1'b1);
      cycle(TOHOST_A, 32'h5, 4'hF, 1'b0, 1'b1);
      cycle(TOHOST_A, 32'h9, 4'b0001, 1'b0, 1'b1);
      check("tohost_first", done_code, 32'h1);

      // Reset mid-stream, with a store attempted during reset
      cycle(32'h400, 32'h7, 4'hF, 1'b0, 1'b1);
      cycle(32'h404, 32'h8, 4'hF, 1'b0, 1'b1);
      cycle(32'h408, 32'h9, 4'hF, 1'b0, 1'b1);
      cycle(32'h400, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
      check("rst_done", 32'(done), 32'h0);
      rd_check(32'h400);
      check("rst_ram_kept", d_mem_rdata, 32'h7);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: w = 4'hF;
            5, 6:          w = 4'h0;
            default:       w = 4'($urandom_range(1, 14));
         endcase
         d = $urandom;
         cycle(pick_addr(), d, w, $urandom_range(0, 1) == 1, $urandom_range(0, 49) != 0);
         rd_check(pick_addr());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
